priority_encoder_rr: RTL and testbench

- Registered, parametrised successor to the 8-switch combinational priority encoder.
- Samples an N-bit request vector and selects one active request. It presents the winner as a binary index plus a one-hot grant, and holds it under a valid/ack handshake.
- Supports two priority modes:
  - fixed: bit 0 highest, matching the legacy encoder.
  - round-robin: rotating priority, for fair arbitration between FPGA switch/button sources and downstream consumers.

---
 rtl/priority_encoder_rr.sv | 115 +++++++++++
 tb/tb_priority_encoder_rr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_rr.sv
// Registered N-input priority encoder with valid/ack handshake.
// MODE=0 is fixed priority (bit 0 highest); MODE=1 rotates priority past the last acknowledged winner.
module priority_encoder_rr #(
  parameter int unsigned N    = 8,
  parameter int unsigned MODE = 0,
  localparam int unsigned W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant
);

  localparam logic [N-1:0] GRANT_ONE = N'(1);
  localparam logic [W-1:0] IDX_LAST  = W'(N - 1);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] grant_q, grant_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         acked_c;
  logic         load_c;
  logic [W-1:0] ptr_inc_c;
  logic [W-1:0] start_c;
  logic         any_c;
  logic         hi_found_c;
  logic [W-1:0] hi_idx_c;
  logic [W-1:0] lo_idx_c;
  logic [W-1:0] sel_c;

  // Handshake qualifiers and the pointer value that follows an acknowledged grant.
  always_comb begin
    acked_c   = valid_q && ack;
    load_c    = en && (!valid_q || ack);
    ptr_inc_c = (idx_q == IDX_LAST) ? '0 : idx_q + W'(1);
    if (MODE == 0) begin
      start_c = '0;
    end else if (acked_c) begin
      // Scan from past the winner being consumed so it is never re-granted immediately.
      start_c = ptr_inc_c;
    end else begin
      start_c = ptr_q;
    end
  end

  // Lowest set bit at or above start wins, else lowest set bit overall (modulo-N wrap).
  always_comb begin
    hi_found_c = 1'b0;
    hi_idx_c   = '0;
    lo_idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx_c = W'(i);
        if (W'(i) >= start_c) begin
          hi_found_c = 1'b1;
          hi_idx_c   = W'(i);
        end
      end
    end
    any_c = |req;
    sel_c = hi_found_c ? hi_idx_c : lo_idx_c;
  end

  // Next-state for the presented grant and the rotation pointer.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;

    if (load_c) begin
      if (any_c) begin
        valid_d = 1'b1;
        idx_d   = sel_c;
        grant_d = GRANT_ONE << sel_c;
      end else begin
        valid_d = 1'b0;
        idx_d   = '0;
        grant_d = '0;
      end
    end else if (acked_c) begin
      valid_d = 1'b0;
      idx_d   = '0;
      grant_d = '0;
    end

    if ((MODE == 1) && acked_c) begin
      ptr_d = ptr_inc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid = valid_q;
  assign idx   = idx_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: three instances (fixed N=8, round-robin N=8, round-robin N=5)
// share one stimulus stream and are compared every cycle against a scan-based reference model.
module tb_priority_encoder_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        ack;
  logic [63:0] req_r;

  logic       v0, v1, v2;
  logic [2:0] i0, i1, i2;
  logic [7:0] g0, g1;
  logic [4:0] g2;

  int errors = 0;
  int checks = 0;

  localparam int NI = 3;
  int n_a[NI]    = '{8, 8, 5};
  int mode_a[NI] = '{0, 1, 1};

  bit m_valid[NI];
  int m_idx[NI];
  int m_ptr[NI];
  bit armed = 1'b0;

  logic [63:0] d_valid[NI];
  logic [63:0] d_idx[NI];
  logic [63:0] d_grant[NI];

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(8), .MODE(0)) u_fix8 (
    .clk(clk), .rst_n(rst_n), .req(req_r[7:0]), .en(en), .ack(ack),
    .valid(v0), .idx(i0), .grant(g0)
  );

  priority_encoder_rr #(.N(8), .MODE(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .req(req_r[7:0]), .en(en), .ack(ack),
    .valid(v1), .idx(i1), .grant(g1)
  );

  priority_encoder_rr #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(req_r[4:0]), .en(en), .ack(ack),
    .valid(v2), .idx(i2), .grant(g2)
  );

  assign d_valid[0] = 64'(v0);
  assign d_valid[1] = 64'(v1);
  assign d_valid[2] = 64'(v2);
  assign d_idx[0]   = 64'(i0);
  assign d_idx[1]   = 64'(i1);
  assign d_idx[2]   = 64'(i2);
  assign d_grant[0] = 64'(g0);
  assign d_grant[1] = 64'(g1);
  assign d_grant[2] = 64'(g2);

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  // First requesting source when scanning start, start+1, ... modulo n; -1 if none.
  function automatic int pick(input logic [63:0] r, input int n, input int start);
    for (int k = 0; k < n; k++) begin
      int p;
      p = (start + k) % n;
      if (((r >> p) & 64'd1) != 64'd0) return p;
    end
    return -1;
  endfunction

  // Reference model: advances on the same edge as the DUTs from the inputs present at that edge.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit acked;
      int nxt;
      int w;
      if (!rst_n) begin
        m_valid[k] = 1'b0;
        m_idx[k]   = 0;
        m_ptr[k]   = 0;
      end else begin
        acked = m_valid[k] && ack;
        nxt   = m_ptr[k];
        if (mode_a[k] == 1 && acked) nxt = (m_idx[k] + 1) % n_a[k];
        if (en && (!m_valid[k] || ack)) begin
          w = pick(req_r, n_a[k], (mode_a[k] == 0) ? 0 : nxt);
          m_valid[k] = (w >= 0);
          m_idx[k]   = (w >= 0) ? w : 0;
        end else if (acked) begin
          m_valid[k] = 1'b0;
          m_idx[k]   = 0;
        end
        m_ptr[k] = nxt;
      end
    end
    if (!rst_n) armed = 1'b1;
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < NI; k++) begin
        check("valid", k, d_valid[k], 64'(m_valid[k]));
        check("idx",   k, d_idx[k],   64'(m_idx[k]));
        check("grant", k, d_grant[k], m_valid[k] ? (64'd1 << m_idx[k]) : 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rn, input logic e, input logic a, input logic [63:0] r);
    rst_n = rn;
    en    = e;
    ack   = a;
    req_r = r;
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    tick();

    // Empty requests never produce a grant.
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    tick();
    check("lit_empty_valid", 0, 64'(v0), 64'd0);
    check("lit_empty_grant", 1, 64'(g1), 64'd0);
    tick();
    check("lit_empty_idx", 2, 64'(i2), 64'd0);

    // Fixed picks bit 3 every time; round-robin N=8 walks 3,5,7,3.
    drive(1'b1, 1'b1, 1'b1, 64'hA8);
    tick();
    check("lit_fix_idx", 0, 64'(i0), 64'd3);
    check("lit_fix_grant", 0, 64'(g0), 64'h08);
    check("lit_rr_a8", 1, 64'(i1), 64'd3);
    tick();
    check("lit_fix_rep", 0, 64'(i0), 64'd3);
    check("lit_rr_a8", 1, 64'(i1), 64'd5);
    tick();
    check("lit_rr_a8", 1, 64'(i1), 64'd7);
    tick();
    check("lit_rr_a8", 1, 64'(i1), 64'd3);

    // Consume without reload, then hold until ack.
    drive(1'b1, 1'b0, 1'b1, 64'hA8);
    tick();
    check("lit_consume_valid", 0, 64'(v0), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 64'h10);
    tick();
    check("lit_hold_idx", 0, 64'(i0), 64'd4);
    drive(1'b1, 1'b1, 1'b0, 64'h01);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("lit_hold_idx", 0, 64'(i0), 64'd4);
    end
    drive(1'b1, 1'b1, 1'b1, 64'h01);
    tick();
    check("lit_ack_idx", 0, 64'(i0), 64'd0);

    // Round-robin fairness with all requests set.
    drive(1'b0, 1'b1, 1'b1, 64'hFF);
    tick();
    drive(1'b1, 1'b1, 1'b1, 64'hFF);
    for (int c = 0; c < 9; c++) begin
      tick();
      check("lit_rr_ff", 1, 64'(i1), 64'(c % 8));
    end

    // Modulo-5 skip and wrap.
    drive(1'b0, 1'b1, 1'b1, 64'h12);
    tick();
    drive(1'b1, 1'b1, 1'b1, 64'h12);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("lit_rr5", 2, 64'(i2), (c % 2 == 0) ? 64'd1 : 64'd4);
    end

    // Reset while holding drops the grant and rewinds the pointer.
    drive(1'b0, 1'b1, 1'b0, 64'h40);
    tick();
    drive(1'b1, 1'b1, 1'b0, 64'h40);
    tick();
    check("lit_midhold_idx", 1, 64'(i1), 64'd6);
    drive(1'b1, 1'b1, 1'b0, 64'hFF);
    tick();
    check("lit_midhold_keep", 1, 64'(i1), 64'd6);
    drive(1'b0, 1'b1, 1'b0, 64'hFF);
    tick();
    check("lit_rst_valid", 1, 64'(v1), 64'd0);
    check("lit_rst_grant", 1, 64'(g1), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 64'hFF);
    tick();
    check("lit_after_rst", 1, 64'(i1), 64'd0);

    // Randomized traffic; the model checker covers every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] r;
      case ($urandom_range(0, 3))
        0:       r = 64'h0;
        1:       r = 64'd1 << $urandom_range(0, 7);
        default: r = 64'($urandom_range(0, 255));
      endcase
      drive(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
            r);
      tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
